test_alu: RTL and testbench
===========================

// Module: test_alu
// PURPOSE
//   Registered 4-bit, two-operand ALU producing a 5-bit result (carry/borrow in bit 4).
//   Small datapath leaf: upstream logic drives operands and a 2-bit opcode every cycle.
//   The result is captured on the next clock edge.
//   Optional zero-flag output for downstream branch/compare logic.
// PARAMETERS
//   WIDTH   4   operand width in bits; ans is WIDTH+1 bits
// PORTS
//   clk     in   1         single system clock, rising edge
//   reset   in   1         asynchronous, active-high reset
//   inA     in   WIDTH     operand A, unsigned
//   inB     in   WIDTH     operand B, unsigned
//   op      in   2         opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
//   in_vld  in   1         operands/op valid this cycle
//   ans     out  WIDTH+1   registered result
//   out_vld out  1         ans updated on the last edge
//   zero    out  1         ans == 0 (only with TEST_ALU_ZFLAG_EN)
// BEHAVIOUR
//   - Reset (async assert, sync release) clears ans, out_vld and zero to 0 immediately.
//   - Latency is 1 cycle. On a rising clk edge with in_vld=1, ans <= f(inA,inB,op) and out_vld <= 1.
//   - On a rising clk edge with in_vld=0, ans holds its value and out_vld <= 0.
//   - Arithmetic: operands are zero-extended to WIDTH+1 and the result is taken modulo 2^(WIDTH+1).
//   - ADD: ans = A + B; bit WIDTH is carry-out. 15+15 gives 5'h1E.
//   - SUB: ans = A - B in two's complement. bit WIDTH = 1 iff A < B (borrow).
//     1-2 gives 5'h1F; 0-15 gives 5'h11.
//   - AND / OR: bitwise on WIDTH bits; bit WIDTH is always 0.
//   - No invalid opcode exists; all four codes are defined.
//   - Reset asserted mid-stream wins over in_vld in the same cycle.
//   - No internal state other than the output registers; no stalls or backpressure.
// CONFIGURATION
//   TEST_ALU_ZFLAG_EN defined:
//     - zero port is present.
//     - zero is registered alongside ans: zero <= (next ans == 0) when in_vld=1.
//     - zero holds its value when in_vld=0 and resets to 0.
//   TEST_ALU_ZFLAG_EN undefined:
//     - zero port and its register are absent.
//     - All other behaviour is identical.
// TESTING
//   1. reset=1, any inputs -> ans=0, out_vld=0 without a clock edge.
//   2. in_vld=1, A=1, B=2, op=01 -> next cycle ans=5'h1F, out_vld=1.
//   3. in_vld=1, A=1, B=4, op=01 -> ans=5'h1D.
//      Then in_vld=0 with new inputs -> ans holds 5'h1D, out_vld=0.
//   4. A=15, B=15: op=00 -> 5'h1E; op=10 -> 5'h0F; op=11 -> 5'h0F.
//   5. A=4'hA, B=4'h5: op=10 -> 5'h00 (zero=1 if enabled); op=11 -> 5'h0F.
//   6. A=0, B=0, op=00 -> ans=0.
//      With the macro: zero=1. Then A=1, B=0 -> zero=0.

Source files
------------

// File: rtl/test_alu.sv
// Registered two-operand ALU: ADD/SUB/AND/OR on WIDTH-bit operands, WIDTH+1-bit result.
// Define TEST_ALU_ZFLAG_EN to add the registered zero flag output.
module test_alu #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [1:0]       op,
    input  logic             in_vld,
    output logic [WIDTH:0]   ans,
    output logic             out_vld
`ifdef TEST_ALU_ZFLAG_EN
    ,
    output logic             zero
`endif
);

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpOr  = 2'b11
    } aluOp_e;

    logic [WIDTH:0] aExt;
    logic [WIDTH:0] bExt;
    logic [WIDTH:0] nextAns;

    // Zero-extension makes bit WIDTH the carry on ADD, the borrow on SUB and 0 on AND/OR.
    assign aExt = {1'b0, inA};
    assign bExt = {1'b0, inB};

    always_comb begin
        nextAns = '0;
        unique case (aluOp_e'(op))
            OpAdd: nextAns = aExt + bExt;
            OpSub: nextAns = aExt - bExt;
            OpAnd: nextAns = aExt & bExt;
            OpOr:  nextAns = aExt | bExt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ans     <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                ans <= nextAns;
            end
        end
    end

`ifdef TEST_ALU_ZFLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero <= 1'b0;
        end else if (in_vld) begin
            zero <= (nextAns == '0);
        end
    end
`endif

endmodule

// File: tb/tb_test_alu.sv
// Self-checking bench for test_alu: directed corner cases plus randomized traffic
// against a plain-arithmetic reference model. Zero-flag checks follow TEST_ALU_ZFLAG_EN.
module tb_test_alu;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned MOD   = 1 << (WIDTH + 1);

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [1:0]       op;
    logic             in_vld;
    logic [WIDTH:0]   ans;
    logic             out_vld;
`ifdef TEST_ALU_ZFLAG_EN
    logic             zero;
    logic             expZero;
`endif

    logic [WIDTH:0] expAns;
    logic           expVld;
    int             vectors;
    int             miscompares;

    test_alu #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .inA     (inA),
        .inB     (inB),
        .op      (op),
        .in_vld  (in_vld),
        .ans     (ans),
        .out_vld (out_vld)
`ifdef TEST_ALU_ZFLAG_EN
        ,
        .zero    (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic taken modulo 2^(WIDTH+1).
    function automatic logic [WIDTH:0] refResult(input int a, input int b, input int o);
        int r;
        case (o)
            0:       r = (a + b) % MOD;
            1:       r = (a - b + MOD) % MOD;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[WIDTH:0];
    endfunction

    task automatic modelReset();
        expAns = '0;
        expVld = 1'b0;
`ifdef TEST_ALU_ZFLAG_EN
        expZero = 1'b0;
`endif
    endtask

    // Apply one cycle of stimulus, advance the model, and leave time just past the edge.
    task automatic step(input int a, input int b, input int o, input bit v);
        @(negedge clk);
        inA    = a[WIDTH-1:0];
        inB    = b[WIDTH-1:0];
        op     = o[1:0];
        in_vld = v;
        @(posedge clk);
        #1;
        if (v) begin
            expAns = refResult(a, b, o);
            expVld = 1'b1;
`ifdef TEST_ALU_ZFLAG_EN
            expZero = (refResult(a, b, o) == 0);
`endif
        end else begin
            expVld = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        inA    = 4'h7;
        inB    = 4'h3;
        op     = 2'b00;
        in_vld = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (ans !== 5'h00) begin
            miscompares++;
            $display("FAIL reset_ans: got %h expected %h", ans, 5'h00);
        end
        vectors++;
        if (out_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vld: got %b expected 0", out_vld);
        end
`ifdef TEST_ALU_ZFLAG_EN
        vectors++;
        if (zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_zero: got %b expected 0", zero);
        end
`endif
        @(negedge clk);
        in_vld = 1'b0;
        reset  = 1'b0;
        modelReset();
    endtask

    task automatic test_sub_hold();
        step(1, 2, 1, 1'b1);
        vectors++;
        if (ans !== 5'h1F || out_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_1_2: got ans=%h vld=%b expected ans=1f vld=1", ans, out_vld);
        end
        step(1, 4, 1, 1'b1);
        vectors++;
        if (ans !== 5'h1D || out_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_1_4: got ans=%h vld=%b expected ans=1d vld=1", ans, out_vld);
        end
        step(9, 3, 0, 1'b0);
        vectors++;
        if (ans !== 5'h1D || out_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: got ans=%h vld=%b expected ans=1d vld=0", ans, out_vld);
        end
        step(0, 15, 1, 1'b1);
        vectors++;
        if (ans !== 5'h11) begin
            miscompares++;
            $display("FAIL sub_0_15: got %h expected 11", ans);
        end
    endtask

    task automatic test_boundaries();
        logic [WIDTH:0] want [7];
        int             a [7];
        int             b [7];
        int             o [7];
        a = '{15, 15, 15, 10, 10, 0, 1};
        b = '{15, 15, 15, 5, 5, 0, 0};
        o = '{0, 2, 3, 2, 3, 0, 0};
        want = '{5'h1E, 5'h0F, 5'h0F, 5'h00, 5'h0F, 5'h00, 5'h01};
        for (int i = 0; i < 7; i++) begin
            step(a[i], b[i], o[i], 1'b1);
            vectors++;
            if (ans !== want[i] || out_vld !== 1'b1) begin
                miscompares++;
                $display("FAIL boundary_%0d: A=%0d B=%0d op=%0d got ans=%h vld=%b expected ans=%h vld=1",
                         i, a[i], b[i], o[i], ans, out_vld, want[i]);
            end
`ifdef TEST_ALU_ZFLAG_EN
            vectors++;
            if (zero !== (want[i] == 0)) begin
                miscompares++;
                $display("FAIL boundary_zero_%0d: got %b expected %b", i, zero, want[i] == 0);
            end
`endif
        end
    endtask

    task automatic test_reset_midstream();
        step(3, 4, 0, 1'b1);
        @(negedge clk);
        inA    = 4'h5;
        inB    = 4'h2;
        op     = 2'b00;
        in_vld = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (ans !== 5'h00 || out_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async: got ans=%h vld=%b expected ans=00 vld=0", ans, out_vld);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ans !== 5'h00 || out_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_wins: got ans=%h vld=%b expected ans=00 vld=0", ans, out_vld);
        end
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        step(6, 2, 1, 1'b1);
        vectors++;
        if (ans !== 5'h04 || out_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL after_reset: got ans=%h vld=%b expected ans=04 vld=1", ans, out_vld);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int  a;
            int  b;
            int  o;
            bit  v;
            a = int'($urandom_range(0, (1 << WIDTH) - 1));
            b = int'($urandom_range(0, (1 << WIDTH) - 1));
            o = int'($urandom_range(0, 3));
            v = ($urandom_range(0, 3) != 0);
            step(a, b, o, v);
            vectors++;
            if (ans !== expAns || out_vld !== expVld) begin
                miscompares++;
                $display("FAIL random_%0d: A=%0d B=%0d op=%0d vld=%b got ans=%h out_vld=%b expected ans=%h out_vld=%b",
                         i, a, b, o, v, ans, out_vld, expAns, expVld);
            end
`ifdef TEST_ALU_ZFLAG_EN
            vectors++;
            if (zero !== expZero) begin
                miscompares++;
                $display("FAIL random_zero_%0d: got %b expected %b", i, zero, expZero);
            end
`endif
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelReset();
        test_reset();
        test_sub_hold();
        test_boundaries();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
